clock_digit_sequencer: RTL and testbench

//  Sequences the six BCD digit registers of the HH:MM:SS clock (h1,h0,m1,m0,s1,s0).

---
 rtl/clock_digit_sequencer_if.sv | 28 ++
 rtl/clock_digit_sequencer.sv | 149 ++++++++++++++
 tb/tb_clock_digit_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_digit_sequencer_if.sv
// Digit register bank bus: the sequencer drives per-digit enable/load/data, the bank returns its values.
// Latency: none; this is plain wiring.
// Backpressure: none; the bank accepts a drive on every clock edge.
// Packing for every field: {h1,h0,m1,m0,s1,s0}, bit/nibble 5 = h1 ... 0 = s0.
//   digits_q   : current digit values from the bank
//   digit_en   : per-digit enable (0 = hold)
//   digit_load : per-digit load select (1 = load digits_d nibble, 0 = BCD increment)
//   digits_d   : per-digit load values
interface clock_digit_sequencer_if;
    logic [23:0] digits_q;
    logic [5:0]  digit_en;
    logic [5:0]  digit_load;
    logic [23:0] digits_d;

    modport master (
        input  digits_q,
        output digit_en,
        output digit_load,
        output digits_d
    );

    modport slave (
        output digits_q,
        input  digit_en,
        input  digit_load,
        input  digits_d
    );
endinterface

// File: rtl/clock_digit_sequencer.sv
// Sequences six BCD digit registers (HH:MM:SS, 24h) for run counting, set mode and reset preload.
// Latency: 0 - outputs are combinational from state and inputs; digits update on the same edge.
// Backpressure: none; every tick/button pulse is consumed in the cycle it arrives.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   tick_1hz              : one-cycle pulse, +1 second while running
//   set_mode              : level, 1 = set mode
//   btn_inc_min/btn_inc_hr: one-cycle pulses, +1 minute / +1 hour while in set mode
//   dig                   : digit bank bus (digits_q in; digit_en/digit_load/digits_d out)
//   set_active            : 1 while in SET
//   day_wrap              : one-cycle pulse on the 23:59:59 -> 00:00:00 tick
module clock_digit_sequencer #(
    parameter logic [23:0] INIT_TIME = 24'h000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick_1hz,
    input  logic                           set_mode,
    input  logic                           btn_inc_min,
    input  logic                           btn_inc_hr,
    clock_digit_sequencer_if.master        dig,
    output logic                           set_active,
    output logic                           day_wrap
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_SET  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       hours_23;
    logic       carry_s0, carry_s1, carry_m0, carry_m1;

    logic [5:0]  en;
    logic [5:0]  ld;
    logic [23:0] dat;

    assign {h1, h0, m1, m0, s1, s0} = dig.digits_q;
    assign hours_23 = (h1 == 4'd2) && (h0 == 4'd3);

    // Ripple carry conditions of the seconds/minutes chain.
    assign carry_s0 = (s0 == 4'd9);
    assign carry_s1 = carry_s0 && (s1 == 4'd5);
    assign carry_m0 = carry_s1 && (m0 == 4'd9);
    assign carry_m1 = carry_m0 && (m1 == 4'd5);

    always_comb begin
        en         = '0;
        ld         = '0;
        dat        = '0;   // every load other than the preload loads zero
        set_active = 1'b0;
        day_wrap   = 1'b0;
        state_nxt  = state;

        if (reset) begin
            en        = 6'h3F;
            ld        = 6'h3F;
            dat       = INIT_TIME;
            state_nxt = ST_INIT;
        end else begin
            case (state)
                ST_RUN: begin
                    if (tick_1hz) begin
                        en[0] = 1'b1;
                        if (carry_s0) begin
                            en[1] = 1'b1;
                            ld[1] = (s1 == 4'd5);
                        end
                        if (carry_s1) begin
                            en[2] = 1'b1;
                        end
                        if (carry_m0) begin
                            en[3] = 1'b1;
                            ld[3] = (m1 == 4'd5);
                        end
                        if (carry_m1) begin
                            if (hours_23) begin
                                en[5:4]  = 2'b11;
                                ld[5:4]  = 2'b11;
                                day_wrap = 1'b1;
                            end else if (h0 == 4'd9) begin
                                // h0 wraps 9->0 by itself, h1 takes the carry
                                en[5:4] = 2'b11;
                            end else begin
                                en[4] = 1'b1;
                            end
                        end
                    end
                    // A tick arriving with set_mode is still counted before entering SET.
                    state_nxt = set_mode ? ST_SET : ST_RUN;
                end

                ST_SET: begin
                    set_active = 1'b1;
                    // Seconds held at 00 so counting resumes cleanly on leaving SET.
                    en[1:0] = 2'b11;
                    ld[1:0] = 2'b11;
                    if (btn_inc_min) begin
                        if ((m1 == 4'd5) && (m0 == 4'd9)) begin
                            en[3:2] = 2'b11;
                            ld[3:2] = 2'b11;
                        end else if (m0 == 4'd9) begin
                            en[3:2] = 2'b11;
                        end else begin
                            en[2] = 1'b1;
                        end
                    end
                    if (btn_inc_hr) begin
                        if (hours_23) begin
                            en[5:4] = 2'b11;
                            ld[5:4] = 2'b11;
                        end else if (h0 == 4'd9) begin
                            en[5:4] = 2'b11;
                        end else begin
                            en[4] = 1'b1;
                        end
                    end
                    state_nxt = set_mode ? ST_SET : ST_RUN;
                end

                default: begin
                    // INIT (and the unused encoding) preload the start time.
                    en        = 6'h3F;
                    ld        = 6'h3F;
                    dat       = INIT_TIME;
                    state_nxt = set_mode ? ST_SET : ST_RUN;
                end
            endcase
        end
    end

    assign dig.digit_en   = en;
    assign dig.digit_load = ld;
    assign dig.digits_d   = dat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

endmodule

// File: tb/tb_clock_digit_sequencer.sv
// Bench: two sequencers (different preload times) each driving a six-digit BCD register bank.
// An integer-time reference model predicts each cycle; predictions go through a scoreboard queue.
// Latency: digits are compared one cycle edge after the stimulus; day_wrap/set_active in-cycle.
module tb_clock_digit_sequencer;

    localparam logic [23:0] INIT_A = 24'h000000;
    localparam logic [23:0] INIT_B = 24'h081500;
    localparam int M_INIT = 0;
    localparam int M_RUN  = 1;
    localparam int M_SET  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick_1hz = 1'b0;
    logic set_mode = 1'b0;
    logic btn_inc_min = 1'b0;
    logic btn_inc_hr = 1'b0;
    logic set_active_a, day_wrap_a, set_active_b, day_wrap_b;

    logic        preload = 1'b0;
    logic [23:0] preload_val = '0;
    logic [23:0] bank_a, bank_b;

    clock_digit_sequencer_if bus_a ();
    clock_digit_sequencer_if bus_b ();

    clock_digit_sequencer #(.INIT_TIME(INIT_A)) dut_a (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .set_mode(set_mode),
        .btn_inc_min(btn_inc_min), .btn_inc_hr(btn_inc_hr),
        .dig(bus_a), .set_active(set_active_a), .day_wrap(day_wrap_a)
    );

    clock_digit_sequencer #(.INIT_TIME(INIT_B)) dut_b (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .set_mode(set_mode),
        .btn_inc_min(btn_inc_min), .btn_inc_hr(btn_inc_hr),
        .dig(bus_b), .set_active(set_active_b), .day_wrap(day_wrap_b)
    );

    always #5 clk = ~clk;

    // Six BCD digit registers per bank, following the digit contract.
    function automatic logic [23:0] bank_next(input logic [23:0] q, input logic [5:0] en,
                                              input logic [5:0] ld, input logic [23:0] d);
        logic [23:0] r;
        r = q;
        for (int i = 0; i < 6; i++) begin
            if (en[i]) begin
                if (ld[i])                r[4*i +: 4] = d[4*i +: 4];
                else if (q[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else                      r[4*i +: 4] = q[4*i +: 4] + 4'd1;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        bank_a <= preload ? preload_val
                          : bank_next(bank_a, bus_a.digit_en, bus_a.digit_load, bus_a.digits_d);
        bank_b <= preload ? preload_val
                          : bank_next(bank_b, bus_b.digit_en, bus_b.digit_load, bus_b.digits_d);
    end

    assign bus_a.digits_q = bank_a;
    assign bus_b.digits_q = bank_b;

    // ---------------- reference model ----------------
    int mh [2];
    int mm [2];
    int ms [2];
    int mst = M_INIT;

    function automatic logic [23:0] bcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int init_h(input int k);
        return (k == 0) ? 0 : 8;
    endfunction

    function automatic int init_m(input int k);
        return (k == 0) ? 0 : 15;
    endfunction

    typedef struct {
        logic [23:0] t_a;
        logic [23:0] t_b;
        logic        dw_a;
        logic        dw_b;
        logic        sa;
        logic        chk_en;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic tick, input logic sm, input logic bmin,
                        input logic bhr, input logic rst);
        exp_t e;
        exp_t p;
        logic dwa, dwb, saa, sab;
        logic [5:0] ena;
        @(negedge clk);
        reset = rst; tick_1hz = tick; set_mode = sm; btn_inc_min = bmin; btn_inc_hr = bhr;

        e.dw_a   = !rst && mst == M_RUN && tick && mh[0] == 23 && mm[0] == 59 && ms[0] == 59;
        e.dw_b   = !rst && mst == M_RUN && tick && mh[1] == 23 && mm[1] == 59 && ms[1] == 59;
        e.sa     = !rst && mst == M_SET;
        e.chk_en = !rst && mst == M_RUN && !tick;

        for (int k = 0; k < 2; k++) begin
            if (rst || mst == M_INIT) begin
                mh[k] = init_h(k); mm[k] = init_m(k); ms[k] = 0;
            end else if (mst == M_RUN) begin
                if (tick) begin
                    ms[k]++;
                    if (ms[k] == 60) begin
                        ms[k] = 0; mm[k]++;
                        if (mm[k] == 60) begin
                            mm[k] = 0; mh[k] = (mh[k] + 1) % 24;
                        end
                    end
                end
            end else begin
                ms[k] = 0;
                if (bmin) mm[k] = (mm[k] + 1) % 60;
                if (bhr)  mh[k] = (mh[k] + 1) % 24;
            end
        end
        mst = rst ? M_INIT : (sm ? M_SET : M_RUN);

        e.t_a = bcd(mh[0], mm[0], ms[0]);
        e.t_b = bcd(mh[1], mm[1], ms[1]);
        sb.push_back(e);

        #2;
        dwa = day_wrap_a; dwb = day_wrap_b; saa = set_active_a; sab = set_active_b;
        ena = bus_a.digit_en;

        @(posedge clk);
        #1;
        p = sb.pop_front();
        check("digits_a", bank_a, p.t_a);
        check("digits_b", bank_b, p.t_b);
        check("day_wrap_a", {23'b0, dwa}, {23'b0, p.dw_a});
        check("day_wrap_b", {23'b0, dwb}, {23'b0, p.dw_b});
        check("set_active_a", {23'b0, saa}, {23'b0, p.sa});
        check("set_active_b", {23'b0, sab}, {23'b0, p.sa});
        if (p.chk_en) check("idle_en_a", {18'b0, ena}, 24'h0);
    endtask

    // Backdoor load of both banks (the bench owns the registers); call only while running.
    task automatic preload_time(input int h, input int m, input int s);
        @(negedge clk);
        reset = 1'b0; tick_1hz = 1'b0; set_mode = 1'b0; btn_inc_min = 1'b0; btn_inc_hr = 1'b0;
        preload = 1'b1;
        preload_val = bcd(h, m, s);
        @(posedge clk);
        #1;
        preload = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mh[k] = h; mm[k] = m; ms[k] = s;
        end
        mst = M_RUN;
    endtask

    initial begin
        logic rsm;
        // 1. reset, preload, idle run
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // 2. minute carry then plain counting
        preload_time(12, 34, 59);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);

        // 3. day wrap
        preload_time(23, 59, 59);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // 4. hour/tens carries
        preload_time(9, 59, 59);
        step(1, 0, 0, 0, 0);
        preload_time(19, 59, 59);
        step(1, 0, 0, 0, 0);
        preload_time(0, 9, 59);
        step(1, 0, 0, 0, 0);

        // 5. set mode
        preload_time(23, 59, 30);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0);

        // 6. reset in the middle of set mode, then run
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

        // Random mix near midnight and the 59/9 boundaries
        preload_time(23, 58, 50);
        rsm = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) rsm = ~rsm;
            step(1'($urandom_range(0, 1)), rsm, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
